alu_selftest: RTL and testbench
===============================

ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 Parameter WIDTH, default 6: operand and result width in bits.
REQ-002 Parameter NUM_VECTORS, default 8: number of test vectors in the ROM.
REQ-003 Parameter SETTLE_CYCLES, default 2: number of wait cycles between driving operands and sampling the result; legal range 1..15.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 start  input  1: one-cycle request to run the full vector set.
REQ-007 A  output  WIDTH: operand A driven to the unit under test.
REQ-008 B  output  WIDTH: operand B driven to the unit under test.
REQ-009 C  input  WIDTH: result returned by the combinational unit under test (equality compare: 1 if A==B, else 0).
REQ-010 busy  output  1: high while a run is in progress.
REQ-011 done  output  1: high from the end of a run until the next start or reset.
REQ-012 pass  output  1: high together with done when fail_count is 0.
REQ-013 fail_count  output  $clog2(NUM_VECTORS+1): number of mismatching vectors in the current or last run.
REQ-014 first_fail  output  $clog2(NUM_VECTORS): index of the first mismatching vector; valid only when fail_count is nonzero.
REQ-015 vec_idx  output  $clog2(NUM_VECTORS): index of the vector currently applied.

Function
REQ-016 The FSM SHALL have the states IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL clear fail_count, first_fail and vec_idx, and SHALL move the FSM to DRIVE on the next edge.
REQ-018 start SHALL be ignored in DRIVE, SETTLE and CHECK; a running pass SHALL NOT restart.
REQ-019 In DRIVE, A and B SHALL be loaded from the ROM entry at vec_idx, the settle counter SHALL load SETTLE_CYCLES-1, and the FSM SHALL move to SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles and SHALL then move to CHECK.
REQ-021 In CHECK, C SHALL be compared against the expected value at vec_idx.
- On mismatch, fail_count SHALL increment.
- On a mismatch while fail_count is 0, first_fail SHALL be set to vec_idx.
REQ-022 After CHECK, the FSM SHALL go to DRIVE with vec_idx+1 if vec_idx < NUM_VECTORS-1; otherwise it SHALL go to DONE, and vec_idx SHALL hold its value (no wrap).
REQ-023 Each vector SHALL take SETTLE_CYCLES+2 cycles. done SHALL rise NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles after the start edge.
REQ-024 busy SHALL be 1 exactly in DRIVE, SETTLE and CHECK. done SHALL be 1 exactly in DONE. busy and done SHALL never be 1 together.
REQ-025 A and B SHALL hold their values through SETTLE and CHECK, and SHALL hold the last vector in DONE.
REQ-026 fail_count SHALL saturate at NUM_VECTORS and SHALL never wrap.
REQ-027 All outputs SHALL be registered; no output SHALL depend combinationally on C or start.

Reset
REQ-028 With reset=1 at an edge, the block SHALL enter IDLE and SHALL drive A=0, B=0, busy=0, done=0, pass=0, fail_count=0, first_fail=0 and vec_idx=0 on the following cycle.
REQ-029 reset SHALL take priority over start and over any in-progress state, including reset in the middle of a run.

Structure
REQ-030 Package alu_selftest_pkg SHALL hold:
- the state enum;
- WIDTH;
- the default vector table of {A, B, expected C}: (5,3,0), (2,15,0), (13,40,0), (49,15,0), (19,19,1), (61,54,0), (39,60,0), (49,49,1).
REQ-031 One sub-module, alu_selftest_rom, SHALL return {A, B, expected} for a given index, combinationally, from the package table.

Verification
REQ-032 Correct equality model on C, start pulse -> done rises at cycle 33, pass=1, fail_count=0, busy low in the same cycle.
REQ-033 Model with C stuck at 0 -> fail_count=2, first_fail=4, pass=0.
REQ-034 start pulsed again at vector 3 mid-run -> ignored; done still rises at cycle 33.
REQ-035 reset asserted during SETTLE of vector 5 -> the next cycle shows IDLE with all outputs at their reset values; a new start runs all 8 vectors.
REQ-036 start while in DONE after a failing run, with a correct model -> fail_count cleared; the new run ends with pass=1.
REQ-037 SETTLE_CYCLES=1 and a correct model -> done at cycle 25; the A/B change points are exactly 3 cycles apart.

Source files
------------

// File: rtl/alu_selftest_pkg.sv
// Shared types and the built-in test-vector table for the ALU self-test sequencer.
// The vector table exercises an equality-compare unit: expected C is 1 only when A == B.
package alu_selftest_pkg;

    localparam int WIDTH       = 6;
    localparam int TABLE_DEPTH = 8;
    localparam int CNT_W       = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] expected;
    } vec_t;

    // Indices beyond the table return an all-zero vector (0 == 0 would expect 1,
    // so such entries are deliberately marked as expecting 0 to flag an oversized run).
    function automatic vec_t vec_entry(input logic [31:0] idx);
        vec_t v;
        v = '0;
        case (idx)
            32'd0:   v = '{a: WIDTH'(5),  b: WIDTH'(3),  expected: WIDTH'(0)};
            32'd1:   v = '{a: WIDTH'(2),  b: WIDTH'(15), expected: WIDTH'(0)};
            32'd2:   v = '{a: WIDTH'(13), b: WIDTH'(40), expected: WIDTH'(0)};
            32'd3:   v = '{a: WIDTH'(49), b: WIDTH'(15), expected: WIDTH'(0)};
            32'd4:   v = '{a: WIDTH'(19), b: WIDTH'(19), expected: WIDTH'(1)};
            32'd5:   v = '{a: WIDTH'(61), b: WIDTH'(54), expected: WIDTH'(0)};
            32'd6:   v = '{a: WIDTH'(39), b: WIDTH'(60), expected: WIDTH'(0)};
            32'd7:   v = '{a: WIDTH'(49), b: WIDTH'(49), expected: WIDTH'(1)};
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/alu_selftest_rom.sv
// Combinational lookup of {A, B, expected C} for one vector index.
module alu_selftest_rom
    import alu_selftest_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic [IDX_W-1:0] idx_i,
    output vec_t             vec_o
);

    always_comb begin
        vec_o = vec_entry(32'(idx_i));
    end

endmodule

// File: rtl/alu_selftest.sv
// Built-in self-test sequencer: drives each ROM vector onto A/B, waits for the unit
// under test to settle, compares C with the expected result and tallies mismatches.
module alu_selftest #(
    parameter  int WIDTH         = alu_selftest_pkg::WIDTH,
    parameter  int NUM_VECTORS   = 8,
    parameter  int SETTLE_CYCLES = 2,
    localparam int FC_W          = $clog2(NUM_VECTORS + 1),
    localparam int IDX_W         = $clog2(NUM_VECTORS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [FC_W-1:0]  fail_count,
    output logic [IDX_W-1:0] first_fail,
    output logic [IDX_W-1:0] vec_idx
);
    import alu_selftest_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [FC_W-1:0]  FC_MAX      = FC_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic [FC_W-1:0]    fail_q, fail_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    vec_t               rom_vec;
    logic               mismatch;

    alu_selftest_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx_i (idx_q),
        .vec_o (rom_vec)
    );

    assign mismatch = (C != WIDTH'(rom_vec.expected));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        first_d = first_q;
        fail_d  = fail_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    fail_d  = '0;
                    first_d = '0;
                    idx_d   = '0;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                a_d     = WIDTH'(rom_vec.a);
                b_d     = WIDTH'(rom_vec.b);
                cnt_d   = SETTLE_LOAD;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    if (fail_q != FC_MAX) begin
                        fail_d = fail_q + 1'b1;
                    end
                    if (fail_q == '0) begin
                        first_d = idx_q;
                    end
                end
                // The last vector leaves vec_idx in place so it still names the final entry.
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DRIVE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        pass_d = done_d && (fail_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            first_q <= '0;
            fail_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            fail_q  <= fail_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign A          = a_q;
    assign B          = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_q;
    assign first_fail = first_q;
    assign vec_idx    = idx_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: two instances (SETTLE_CYCLES 2 and 1), each fed by an
// equality-compare model whose result can be stuck at 0 or flipped per vector.
module tb_alu_selftest;

    localparam int W = 6;
    localparam int N = 8;
    localparam int TA[N]  = '{5, 2, 13, 49, 19, 61, 39, 49};
    localparam int TBV[N] = '{3, 15, 40, 15, 19, 54, 60, 49};
    localparam int TE[N]  = '{0, 0, 0, 0, 1, 0, 0, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, rst1, start0, start1;
    logic [W-1:0] a0, b0, c0, a1, b1, c1;
    logic         busy0, done0, pass0, busy1, done1, pass1;
    logic [3:0]   fc0, fc1;
    logic [2:0]   ff0, ff1, vi0, vi1;
    logic         stuck0, stuck1;
    logic [N-1:0] mask0, mask1;

    int passes = 0;
    int checks = 0;
    int sel    = 0;

    // Unit-under-test model: equality compare, optionally corrupted on chosen vectors.
    function automatic logic [W-1:0] c_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic stuck, input logic [N-1:0] mask);
        logic r;
        r = (a == b);
        for (int i = 0; i < N; i++) begin
            if (a == W'(TA[i]) && b == W'(TBV[i])) r = r ^ mask[i];
        end
        if (stuck) r = 1'b0;
        return {{(W-1){1'b0}}, r};
    endfunction

    assign c0 = c_model(a0, b0, stuck0, mask0);
    assign c1 = c_model(a1, b1, stuck1, mask1);

    alu_selftest dut0 (
        .clk(clk), .reset(rst0), .start(start0), .A(a0), .B(b0), .C(c0),
        .busy(busy0), .done(done0), .pass(pass0), .fail_count(fc0),
        .first_fail(ff0), .vec_idx(vi0)
    );

    alu_selftest #(.WIDTH(6), .NUM_VECTORS(8), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .reset(rst1), .start(start1), .A(a1), .B(b1), .C(c1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1),
        .first_fail(ff1), .vec_idx(vi1)
    );

    logic [W-1:0] a_s, b_s;
    logic         busy_s, done_s, pass_s;
    logic [3:0]   fc_s;
    logic [2:0]   ff_s, vi_s;

    always_comb begin
        if (sel == 1) begin
            a_s = a1; b_s = b1; busy_s = busy1; done_s = done1; pass_s = pass1;
            fc_s = fc1; ff_s = ff1; vi_s = vi1;
        end else begin
            a_s = a0; b_s = b0; busy_s = busy0; done_s = done0; pass_s = pass0;
            fc_s = fc0; ff_s = ff0; vi_s = vi0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel == 1) start1 = v;
        else          start0 = v;
    endtask

    // Reference: walk the vector table, apply the fault model, tally mismatches.
    task automatic ref_outcome(input logic stuck, input logic [N-1:0] mask,
                               output int fc, output int ff);
        int c;
        fc = 0;
        ff = 0;
        for (int i = 0; i < N; i++) begin
            c = stuck ? 0 : (((TA[i] == TBV[i]) ? 1 : 0) ^ int'(mask[i]));
            if (c != TE[i]) begin
                if (fc == 0) ff = i;
                fc++;
            end
        end
        if (fc > N) fc = N;
    endtask

    // Pulses start on the selected instance and follows the run until done (bounded).
    // Cycle 0 is the cycle start is held high; A/B change points are logged against
    // the expected schedule 2 + k*(settle+2) and the table contents.
    task automatic do_run(input int mid, output int done_cyc, output int bad_sched,
                          output int overlap, output int fc_first);
        int per, cyc, k;
        logic [2*W-1:0] prev;
        per = ((sel == 1) ? 1 : 2) + 2;
        done_cyc = -1; bad_sched = 0; overlap = 0; k = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        cyc = 1;
        fc_first = int'(fc_s);
        prev = {a_s, b_s};
        while (cyc <= 200) begin
            if (busy_s && done_s) overlap++;
            if ({a_s, b_s} != prev) begin
                if (k >= N || cyc != 2 + k * per || a_s != W'(TA[k]) || b_s != W'(TBV[k]))
                    bad_sched++;
                k++;
                prev = {a_s, b_s};
            end
            if (done_s) begin
                done_cyc = cyc;
                break;
            end
            set_start(cyc == mid);
            tick();
            cyc++;
        end
        set_start(1'b0);
        if (k != N) bad_sched++;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        tick();
        tick();
        checks++;
        if ({a0, b0, busy0, done0, pass0, fc0, ff0, vi0} !== '0)
            $display("FAIL reset_dut0 got A=%0d B=%0d busy=%b done=%b pass=%b fc=%0d ff=%0d idx=%0d want all 0",
                     a0, b0, busy0, done0, pass0, fc0, ff0, vi0);
        else passes++;
        checks++;
        if ({a1, b1, busy1, done1, pass1, fc1, ff1, vi1} !== '0)
            $display("FAIL reset_dut1 got A=%0d B=%0d busy=%b done=%b pass=%b fc=%0d ff=%0d idx=%0d want all 0",
                     a1, b1, busy1, done1, pass1, fc1, ff1, vi1);
        else passes++;
        rst0 = 1'b0; rst1 = 1'b0;
        tick();
        checks++;
        if ({busy0, done0, busy1, done1} !== 4'b0000)
            $display("FAIL idle_after_reset got busy0=%b done0=%b busy1=%b done1=%b want 0", busy0, done0, busy1, done1);
        else passes++;
        $display("test_reset: done");
    endtask

    task automatic test_correct_run();
        int dc, bs, ov, f1, efc, eff;
        sel = 0; stuck0 = 1'b0; mask0 = '0;
        ref_outcome(stuck0, mask0, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if (dc !== 1 + N * 4) $display("FAIL correct_done_cycle got=%0d want=%0d", dc, 1 + N * 4); else passes++;
        checks++;
        if (bs !== 0 || ov !== 0) $display("FAIL correct_schedule got bad=%0d overlap=%0d want 0 0", bs, ov); else passes++;
        checks++;
        if ({busy_s, pass_s, fc_s} !== {1'b0, 1'b1, 4'(efc)})
            $display("FAIL correct_result got busy=%b pass=%b fc=%0d want busy=0 pass=1 fc=%0d", busy_s, pass_s, fc_s, efc);
        else passes++;
        checks++;
        if ({a_s, b_s, vi_s} !== {W'(TA[N-1]), W'(TBV[N-1]), 3'(N - 1)})
            $display("FAIL correct_hold got A=%0d B=%0d idx=%0d want A=%0d B=%0d idx=%0d",
                     a_s, b_s, vi_s, TA[N-1], TBV[N-1], N - 1);
        else passes++;
        $display("test_correct_run: done at cycle %0d fc=%0d", dc, fc_s);
    endtask

    task automatic test_stuck_zero();
        int dc, bs, ov, f1, efc, eff;
        sel = 0; stuck0 = 1'b1; mask0 = '0;
        ref_outcome(stuck0, mask0, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if (dc !== 1 + N * 4) $display("FAIL stuck_done_cycle got=%0d want=%0d", dc, 1 + N * 4); else passes++;
        checks++;
        if ({fc_s, ff_s, pass_s} !== {4'(efc), 3'(eff), 1'b0})
            $display("FAIL stuck_result got fc=%0d ff=%0d pass=%b want fc=%0d ff=%0d pass=0", fc_s, ff_s, pass_s, efc, eff);
        else passes++;
        $display("test_stuck_zero: fc=%0d first_fail=%0d", fc_s, ff_s);
    endtask

    task automatic test_restart_after_fail();
        int dc, bs, ov, f1, efc, eff;
        sel = 0; stuck0 = 1'b0; mask0 = '0;
        ref_outcome(stuck0, mask0, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if (f1 !== 0) $display("FAIL restart_clear got fc=%0d at cycle 1 want 0", f1); else passes++;
        checks++;
        if ({dc, pass_s, fc_s} !== {1 + N * 4, 1'b1, 4'(efc)})
            $display("FAIL restart_result got done_cyc=%0d pass=%b fc=%0d want %0d 1 %0d", dc, pass_s, fc_s, 1 + N * 4, efc);
        else passes++;
        $display("test_restart_after_fail: pass=%b", pass_s);
    endtask

    task automatic test_mid_start();
        int dc, bs, ov, f1;
        sel = 0; stuck0 = 1'b0; mask0 = '0;
        do_run(14, dc, bs, ov, f1);
        checks++;
        if (dc !== 1 + N * 4 || bs !== 0)
            $display("FAIL mid_start got done_cyc=%0d bad=%0d want %0d 0", dc, bs, 1 + N * 4);
        else passes++;
        $display("test_mid_start: done at cycle %0d", dc);
    endtask

    task automatic test_random_faults();
        int dc, bs, ov, f1, efc, eff, mid;
        sel = 0; stuck0 = 1'b0;
        for (int it = 0; it < 6; it++) begin
            mask0 = N'($urandom);
            mid = $urandom_range(32, 2);
            ref_outcome(stuck0, mask0, efc, eff);
            do_run(mid, dc, bs, ov, f1);
            checks++;
            if (dc !== 1 + N * 4 || bs !== 0 || ov !== 0)
                $display("FAIL rand_timing mask=%b got done_cyc=%0d bad=%0d overlap=%0d want %0d 0 0", mask0, dc, bs, ov, 1 + N * 4);
            else passes++;
            checks++;
            if (fc_s !== 4'(efc) || pass_s !== (efc == 0) || (efc != 0 && ff_s !== 3'(eff)))
                $display("FAIL rand_result mask=%b got fc=%0d ff=%0d pass=%b want fc=%0d ff=%0d", mask0, fc_s, ff_s, pass_s, efc, eff);
            else passes++;
            $display("test_random_faults: mask=%b mid_start=%0d fc=%0d ff=%0d", mask0, mid, fc_s, ff_s);
        end
    endtask

    task automatic test_reset_midrun();
        int dc, bs, ov, f1, efc, eff;
        sel = 0; stuck0 = 1'b0; mask0 = 8'b0000_0101;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (21) tick();
        checks++;
        if ({busy0, fc0} !== {1'b1, 4'd2}) $display("FAIL pre_reset got busy=%b fc=%0d want busy=1 fc=2", busy0, fc0); else passes++;
        rst0 = 1'b1;
        tick();
        checks++;
        if ({a0, b0, busy0, done0, pass0, fc0, ff0, vi0} !== '0)
            $display("FAIL midrun_reset got A=%0d B=%0d busy=%b done=%b pass=%b fc=%0d ff=%0d idx=%0d want all 0",
                     a0, b0, busy0, done0, pass0, fc0, ff0, vi0);
        else passes++;
        rst0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({busy0, done0} !== 2'b00) $display("FAIL stays_idle got busy=%b done=%b want 0 0", busy0, done0); else passes++;
        mask0 = '0;
        ref_outcome(stuck0, mask0, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if ({dc, bs, pass_s, fc_s} !== {1 + N * 4, 0, 1'b1, 4'(efc)})
            $display("FAIL post_reset_run got done_cyc=%0d bad=%0d pass=%b fc=%0d want %0d 0 1 %0d",
                     dc, bs, pass_s, fc_s, 1 + N * 4, efc);
        else passes++;
        $display("test_reset_midrun: rerun done at cycle %0d", dc);
    endtask

    task automatic test_settle_one();
        int dc, bs, ov, f1, efc, eff;
        sel = 1; stuck1 = 1'b0; mask1 = '0;
        ref_outcome(stuck1, mask1, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if (dc !== 1 + N * 3) $display("FAIL settle1_done_cycle got=%0d want=%0d", dc, 1 + N * 3); else passes++;
        checks++;
        if (bs !== 0 || ov !== 0) $display("FAIL settle1_schedule got bad=%0d overlap=%0d want 0 0", bs, ov); else passes++;
        checks++;
        if ({pass_s, fc_s} !== {1'b1, 4'(efc)}) $display("FAIL settle1_result got pass=%b fc=%0d want 1 %0d", pass_s, fc_s, efc); else passes++;
        mask1 = N'($urandom) | 8'b0100_0000;
        ref_outcome(stuck1, mask1, efc, eff);
        do_run(-1, dc, bs, ov, f1);
        checks++;
        if ({dc, fc_s, ff_s, pass_s} !== {1 + N * 3, 4'(efc), 3'(eff), 1'b0})
            $display("FAIL settle1_faults mask=%b got done_cyc=%0d fc=%0d ff=%0d pass=%b want %0d %0d %0d 0",
                     mask1, dc, fc_s, ff_s, pass_s, 1 + N * 3, efc, eff);
        else passes++;
        $display("test_settle_one: done at cycle %0d fc=%0d", dc, fc_s);
        sel = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
        stuck0 = 1'b0; stuck1 = 1'b0; mask0 = '0; mask1 = '0;
        test_reset();
        test_correct_run();
        test_stuck_zero();
        test_restart_after_fail();
        test_mid_start();
        test_random_faults();
        test_reset_midrun();
        test_settle_one();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
